// File: rtl/cpu_trace_buffer_if.sv
// Sample, control and readout bundle between a CPU core and its trace buffer.
// The master side drives samples and control; the slave side is the buffer.
interface cpu_trace_buffer_if #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int N_CHANNELS       = 6,
    parameter int DEPTH            = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                             sample_en;
    logic [WORDSIZE-1:0]              pc_addr;
    logic [INSTRUCTION_SIZE-1:0]      im_instr;
    logic [N_CHANNELS*WORDSIZE-1:0]   ch_data;
    logic                             arm;
    logic                             abort;
    logic [1:0]                       trig_mode;
    logic [WORDSIZE-1:0]              trig_value;
    logic                             busy;
    logic                             done;
    logic                             rd_valid;
    logic                             rd_ready;
    logic [WORDSIZE-1:0]              rd_pc;
    logic [INSTRUCTION_SIZE-1:0]      rd_instr;
    logic [N_CHANNELS*WORDSIZE-1:0]   rd_ch;
    logic [15:0]                      rd_seq;
    logic                             rd_is_trig;
    logic [CW-1:0]                    rd_count;

    modport master (
        output sample_en, pc_addr, im_instr, ch_data, arm, abort,
               trig_mode, trig_value, rd_ready,
        input  busy, done, rd_valid, rd_pc, rd_instr, rd_ch, rd_seq,
               rd_is_trig, rd_count
    );

    modport slave (
        input  sample_en, pc_addr, im_instr, ch_data, arm, abort,
               trig_mode, trig_value, rd_ready,
        output busy, done, rd_valid, rd_pc, rd_instr, rd_ch, rd_seq,
               rd_is_trig, rd_count
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Triggered circular trace buffer: records PC, instruction and datapath channels
// with pre-trigger history, then replays the kept records oldest-first.
module cpu_trace_buffer #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int N_CHANNELS       = 6,
    parameter int DEPTH            = 16,
    parameter int PRETRIGGER       = 4
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_n,
    cpu_trace_buffer_if.slave     bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int CHW  = N_CHANNELS * WORDSIZE;
    localparam int POST = DEPTH - PRETRIGGER - 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    typedef struct packed {
        logic [WORDSIZE-1:0]         pc;
        logic [INSTRUCTION_SIZE-1:0] instr;
        logic [CHW-1:0]              ch;
        logic [15:0]                 seq;
        logic                        is_trig;
    } rec_t;

    state_t          r_state;
    rec_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_post_cnt;
    logic [15:0]     r_seq;
    logic            r_rd_valid;
    logic [CW-1:0]   r_rd_count;
    rec_t            r_rd_rec;

    logic            w_capturing;
    logic            w_wr_en;
    logic            w_match;
    logic            w_fire;
    logic            w_xfer;
    logic [AW-1:0]   w_rd_start;
    rec_t            w_wr_rec;

    assign w_capturing = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign w_wr_en     = bus.sample_en && !bus.abort && w_capturing;
    assign w_fire      = w_wr_en && (r_state == S_ARMED) && w_match;
    assign w_xfer      = r_rd_valid && bus.rd_ready;
    // With a full buffer the oldest record sits at the write pointer itself.
    assign w_rd_start  = r_wr_ptr - r_count[AW-1:0];
    assign w_wr_rec    = {bus.pc_addr, bus.im_instr, bus.ch_data, r_seq, w_fire};

    // NOTE: a default on every path keeps always_comb from inferring a latch.
    always_comb begin
        w_match = 1'b0;
        case (bus.trig_mode)
            2'd0:    w_match = 1'b1;
            2'd1:    w_match = (bus.pc_addr == bus.trig_value);
            2'd2:    w_match = (bus.im_instr[6:0] == bus.trig_value[6:0]);
            default: w_match = 1'b0;
        endcase
    end

    // NOTE: record storage has no reset; r_count gates what is readable, so
    // stale contents are never replayed and the array can map to RAM.
    always_ff @(posedge cpu_clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= w_wr_rec;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_seq      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_count <= '0;
            r_rd_rec   <= '0;
        end else if (bus.abort) begin
            r_state    <= S_IDLE;
            r_rd_valid <= 1'b0;
            r_rd_count <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_seq    <= r_seq + 1'b1;
                if (r_count != CW'(DEPTH))
                    r_count <= r_count + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.arm) begin
                        r_state  <= S_ARMED;
                        r_wr_ptr <= '0;
                        r_count  <= '0;
                        r_seq    <= '0;
                    end
                end
                S_ARMED: begin
                    if (w_fire) begin
                        r_post_cnt <= AW'(POST);
                        r_state    <= (POST == 0) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_wr_en) begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                        if (r_post_cnt == AW'(1))
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!r_rd_valid) begin
                        r_rd_rec   <= r_mem[w_rd_start];
                        r_rd_ptr   <= w_rd_start + 1'b1;
                        r_rd_count <= r_count;
                        r_rd_valid <= 1'b1;
                    end else if (w_xfer) begin
                        if (r_rd_count == CW'(1)) begin
                            r_rd_valid <= 1'b0;
                            r_rd_count <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_rd_rec   <= r_mem[r_rd_ptr];
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                            r_rd_count <= r_rd_count - 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = w_capturing;
    assign bus.done       = (r_state == S_DONE);
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_pc      = r_rd_rec.pc;
    assign bus.rd_instr   = r_rd_rec.instr;
    assign bus.rd_ch      = r_rd_rec.ch;
    assign bus.rd_seq     = r_rd_rec.seq;
    assign bus.rd_is_trig = r_rd_rec.is_trig;
    assign bus.rd_count   = r_rd_count;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer with DEPTH=8, PRETRIGGER=3 (POST=4).
module tb_cpu_trace_buffer;
    localparam int WS  = 64;
    localparam int IS  = 32;
    localparam int NC  = 6;
    localparam int DEP = 8;
    localparam int PRE = 3;
    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] BEQ  = 32'h0020_8063;

    logic cpu_clk;
    logic cpu_rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [WS-1:0]    g_pc    [8];
    logic [IS-1:0]    g_instr [8];
    logic [NC*WS-1:0] g_ch    [8];
    logic [15:0]      g_seq   [8];
    logic             g_trig  [8];
    logic [3:0]       g_cnt   [8];

    cpu_trace_buffer_if #(.WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .N_CHANNELS(NC),
                          .DEPTH(DEP)) bus ();

    cpu_trace_buffer #(.WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .N_CHANNELS(NC),
                       .DEPTH(DEP), .PRETRIGGER(PRE)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .bus       (bus)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [NC*WS-1:0] ch_of(input logic [WS-1:0] pc);
        logic [NC*WS-1:0] r;
        for (int i = 0; i < NC; i++)
            r[i*WS +: WS] = pc ^ (64'(i + 1) << 8);
        return r;
    endfunction

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic sample(input logic [WS-1:0] pc, input logic [IS-1:0] instr);
        bus.sample_en = 1'b1;
        bus.pc_addr   = pc;
        bus.im_instr  = instr;
        bus.ch_data   = ch_of(pc);
        tick();
        bus.sample_en = 1'b0;
    endtask

    task automatic arm_with(input logic [1:0] mode, input logic [WS-1:0] value);
        bus.trig_mode  = mode;
        bus.trig_value = value;
        bus.arm        = 1'b1;
        tick();
        bus.arm        = 1'b0;
    endtask

    task automatic read_records(input int n, input int budget, output int got);
        got = 0;
        bus.rd_ready = 1'b1;
        for (int c = 0; c < budget && got < n; c++) begin
            if (bus.rd_valid) begin
                g_pc[got]    = bus.rd_pc;
                g_instr[got] = bus.rd_instr;
                g_ch[got]    = bus.rd_ch;
                g_seq[got]   = bus.rd_seq;
                g_trig[got]  = bus.rd_is_trig;
                g_cnt[got]   = bus.rd_count;
                got++;
            end
            tick();
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        arm_with(2'd3, '0);
        repeat (3) sample(64'h40, ADDI);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL reset_pre_busy: got %b want 1", bus.busy);
        end
        @(posedge cpu_clk);
        #3 cpu_rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.rd_valid, bus.rd_count} !== 7'b0) begin
            bad++; $display("FAIL reset_async: busy=%b done=%b valid=%b count=%0d want all 0",
                            bus.busy, bus.done, bus.rd_valid, bus.rd_count);
        end
        for (int i = 0; i < 3; i++) begin
            bus.sample_en = ~bus.sample_en;
            tick();
            total++;
            if ({bus.busy, bus.done, bus.rd_valid, bus.rd_count} !== 7'b0) begin
                bad++; $display("FAIL reset_hold[%0d]: busy=%b done=%b valid=%b count=%0d want all 0",
                                i, bus.busy, bus.done, bus.rd_valid, bus.rd_count);
            end
        end
        bus.sample_en = 1'b0;
        cpu_rst_n = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL reset_release: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_mode0();
        int got;
        arm_with(2'd0, '0);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL m0_armed_busy: got %b want 1", bus.busy);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.done !== 1'b0) begin
                bad++; $display("FAIL m0_early_done[%0d]: got %b want 0", k, bus.done);
            end
            sample(64'(4 * k), ADDI);
        end
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL m0_done: done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
        sample(64'h14, ADDI);
        read_records(5, 20, got);
        total++;
        if (got !== 5) begin
            bad++; $display("FAIL m0_count: got %0d records want 5", got);
        end
        for (int k = 0; k < got; k++) begin
            total++;
            if (g_pc[k] !== 64'(4 * k) || g_seq[k] !== 16'(k) ||
                g_trig[k] !== (k == 0) || g_cnt[k] !== 4'(5 - k) ||
                g_ch[k] !== ch_of(64'(4 * k))) begin
                bad++; $display("FAIL m0_rec[%0d]: pc=%h seq=%0d trig=%b cnt=%0d want pc=%h seq=%0d trig=%b cnt=%0d",
                                k, g_pc[k], g_seq[k], g_trig[k], g_cnt[k],
                                64'(4 * k), k, (k == 0), 5 - k);
            end
        end
        tick();
        total++;
        if (bus.rd_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL m0_idle: valid=%b done=%b busy=%b want 0 0 0",
                            bus.rd_valid, bus.done, bus.busy);
        end
    endtask

    task automatic test_mode1();
        int ns = 0;
        int got;
        arm_with(2'd1, 64'h28);
        for (int k = 0; k < 20 && !bus.done; k++) begin
            sample(64'(4 * k), ADDI);
            ns++;
        end
        total++;
        if (ns !== 15 || bus.done !== 1'b1) begin
            bad++; $display("FAIL m1_samples: got %0d done=%b want 15 1", ns, bus.done);
        end
        read_records(8, 30, got);
        total++;
        if (got !== 8) begin
            bad++; $display("FAIL m1_count: got %0d records want 8", got);
        end
        for (int k = 0; k < got; k++) begin
            total++;
            if (g_seq[k] !== 16'(7 + k) || g_pc[k] !== 64'(32'h1C + 4 * k) ||
                g_trig[k] !== (k == 3) || g_cnt[k] !== 4'(8 - k)) begin
                bad++; $display("FAIL m1_rec[%0d]: pc=%h seq=%0d trig=%b cnt=%0d want pc=%h seq=%0d trig=%b cnt=%0d",
                                k, g_pc[k], g_seq[k], g_trig[k], g_cnt[k],
                                64'(32'h1C + 4 * k), 7 + k, (k == 3), 8 - k);
            end
        end
    endtask

    task automatic test_mode2();
        int ns = 0;
        int got;
        int ntrig = 0;
        arm_with(2'd2, 64'h63);
        for (int k = 0; k < 20 && !bus.done; k++) begin
            sample(64'(16'h200 + 4 * k), (k == 5) ? BEQ : ADDI);
            ns++;
        end
        total++;
        if (ns !== 10) begin
            bad++; $display("FAIL m2_samples: got %0d want 10", ns);
        end
        read_records(8, 30, got);
        for (int k = 0; k < got; k++)
            if (g_trig[k]) ntrig++;
        total++;
        if (got !== 8 || ntrig !== 1) begin
            bad++; $display("FAIL m2_trig_count: records=%0d trig=%0d want 8 1", got, ntrig);
        end
        total++;
        if (g_trig[3] !== 1'b1 || g_seq[3] !== 16'd5 || g_instr[3][6:0] !== 7'h63) begin
            bad++; $display("FAIL m2_trig_rec: trig=%b seq=%0d op=%h want 1 5 63",
                            g_trig[3], g_seq[3], g_instr[3][6:0]);
        end
    endtask

    task automatic test_mode3();
        arm_with(2'd3, 64'h0);
        for (int k = 0; k < 40; k++)
            sample(64'(4 * k), BEQ);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL m3_never: done=%b busy=%b want 0 1", bus.done, bus.busy);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL m3_abort: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_backpressure();
        int c = 0;
        arm_with(2'd0, '0);
        for (int k = 0; k < 5; k++)
            sample(64'(4 * k), ADDI);
        bus.rd_ready = 1'b0;
        while (!bus.rd_valid && c < 10) begin
            tick();
            c++;
        end
        total++;
        if (bus.rd_valid !== 1'b1) begin
            bad++; $display("FAIL bp_valid_timeout: rd_valid=%b want 1", bus.rd_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 64'h0 || bus.rd_count !== 4'd5 ||
                bus.rd_seq !== 16'd0) begin
                bad++; $display("FAIL bp_hold[%0d]: valid=%b pc=%h cnt=%0d seq=%0d want 1 0 5 0",
                                i, bus.rd_valid, bus.rd_pc, bus.rd_count, bus.rd_seq);
            end
        end
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 64'(4 * k) || bus.rd_count !== 4'(5 - k)) begin
                bad++; $display("FAIL bp_stream[%0d]: valid=%b pc=%h cnt=%0d want 1 %h %0d",
                                k, bus.rd_valid, bus.rd_pc, bus.rd_count, 64'(4 * k), 5 - k);
            end
            tick();
        end
        bus.rd_ready = 1'b0;
        total++;
        if (bus.rd_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL bp_idle: valid=%b done=%b busy=%b want 0 0 0",
                            bus.rd_valid, bus.done, bus.busy);
        end
    endtask

    task automatic test_abort_rearm();
        int got;
        arm_with(2'd0, '0);
        sample(64'h0, ADDI);
        sample(64'h4, ADDI);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL ab_capture_busy: busy=%b want 1", bus.busy);
        end
        bus.abort = 1'b1;
        sample(64'h8, ADDI);
        bus.abort = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_valid !== 1'b0) begin
            bad++; $display("FAIL ab_idle: busy=%b done=%b valid=%b want 0 0 0",
                            bus.busy, bus.done, bus.rd_valid);
        end
        bus.abort = 1'b1;
        arm_with(2'd0, '0);
        bus.abort = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL ab_arm_abort: busy=%b want 0", bus.busy);
        end
        arm_with(2'd0, '0);
        for (int k = 0; k < 5; k++)
            sample(64'(16'h100 + 4 * k), ADDI);
        read_records(5, 20, got);
        total++;
        if (got !== 5 || g_seq[0] !== 16'd0 || g_pc[0] !== 64'h100 || g_cnt[0] !== 4'd5 ||
            g_seq[4] !== 16'd4) begin
            bad++; $display("FAIL ab_rearm: records=%0d seq0=%0d pc0=%h cnt0=%0d seq4=%0d want 5 0 100 5 4",
                            got, g_seq[0], g_pc[0], g_cnt[0], g_seq[4]);
        end
    endtask

    initial begin
        cpu_rst_n      = 1'b0;
        bus.sample_en  = 1'b0;
        bus.pc_addr    = '0;
        bus.im_instr   = '0;
        bus.ch_data    = '0;
        bus.arm        = 1'b0;
        bus.abort      = 1'b0;
        bus.trig_mode  = 2'd0;
        bus.trig_value = '0;
        bus.rd_ready   = 1'b0;
        repeat (2) tick();
        cpu_rst_n = 1'b1;
        tick();
        test_reset();
        test_mode0();
        test_mode1();
        test_mode2();
        test_mode3();
        test_backpressure();
        test_abort_rearm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Hardware trace buffer for the processor. It samples the PC, the fetched instruction and N generic datapath channels (register-file ports, data-memory output, mux outputs) once per sample strobe. Capture is governed by a programmable trigger with pre-trigger history, and the stored records are replayed oldest-first over a valid/ready port. It sits beside the cpu core and replaces printf-style monitoring with an on-chip, synthesizable history.

Parameters:
WORDSIZE, 64, datapath word width
INSTRUCTION_SIZE, 32, instruction width
N_CHANNELS, 6, number of WORDSIZE-wide observed channels
DEPTH, 16, records stored; power of 2, at least 2
PRETRIGGER, 4, records kept before the trigger; must satisfy 0 <= PRETRIGGER < DEPTH

Ports:
cpu_clk  in  1  sole clock, rising edge
cpu_rst_n  in  1  asynchronous, active-low reset
sample_en  in  1  one record offered this cycle (PC-update strobe)
pc_addr  in  WORDSIZE  current PC
im_instr  in  INSTRUCTION_SIZE  current instruction
ch_data  in  N_CHANNELS*WORDSIZE  channel i at [i*WORDSIZE +: WORDSIZE]
arm  in  1  start capture; pulse
abort  in  1  return to IDLE and discard the buffer; pulse
trig_mode  in  2  0 immediate, 1 PC match, 2 opcode match, 3 never
trig_value  in  WORDSIZE  compare value (mode 2 uses bits [6:0])
busy  out  1  state is ARMED or CAPTURE
done  out  1  state is DONE
rd_valid  out  1  readout record valid
rd_ready  in  1  consumer accepts the record
rd_pc  out  WORDSIZE  record PC
rd_instr  out  INSTRUCTION_SIZE  record instruction
rd_ch  out  N_CHANNELS*WORDSIZE  record channels
rd_seq  out  16  sample index since arm
rd_is_trig  out  1  record is the trigger sample
rd_count  out  $clog2(DEPTH)+1  records remaining, including the current one

Behaviour:
- Reset: state IDLE; all pointers, counters and outputs are 0.
- Storage: circular array of DEPTH records, each holding {pc, instr, ch, seq, is_trig}; wr_ptr wraps modulo DEPTH.
- Stored-record count: saturates at DEPTH.
- seq: 16-bit counter, cleared on arm, incremented on each accepted sample, wraps at 65535.
- POST = DEPTH-PRETRIGGER-1.
- IDLE: arm moves to ARMED and clears wr_ptr, count and seq. sample_en is ignored.
- ARMED: each sample_en writes one record and evaluates the trigger on that same sample.
  - Mode 0: fires on the first sample.
  - Mode 1: fires when pc_addr==trig_value.
  - Mode 2: fires when im_instr[6:0]==trig_value[6:0].
  - Mode 3: never fires.
  - On fire: is_trig=1 and post_cnt=POST. Next state is CAPTURE, or DONE if POST==0.
- CAPTURE: each sample_en writes one record and decrements post_cnt. When post_cnt reaches 0, the state becomes DONE on that same edge.
- Trigger ordering: the trigger is evaluated only in ARMED, so exactly one record has is_trig=1.
- Retained records: min(samples since arm, DEPTH), the most recent ones. At most PRETRIGGER records precede the trigger record.
- DONE: rd_ptr=(wr_ptr-count) mod DEPTH. rd_valid rises the cycle after DONE is entered.
  - rd_* outputs are registered and held stable while rd_valid && !rd_ready.
  - A transfer occurs on rd_valid && rd_ready: the next record appears the following cycle, and rd_count decrements.
  - After the last transfer, rd_valid=0 and the state becomes IDLE.
  - sample_en and arm are ignored in DONE.
- abort: forces IDLE from any state on the next edge, clears rd_valid, count and post_cnt. abort beats arm when both are asserted in the same cycle. A sample_en in the same cycle as abort is not written.
- arm while ARMED or CAPTURE: ignored.
- Asynchronous reset mid-operation: immediate return to the reset values; no records survive.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert cpu_rst_n=0 mid-cycle -> busy, done, rd_valid and rd_count are 0 immediately. Hold reset and toggle sample_en -> no change.
- Mode 0, DEPTH=8, PRETRIGGER=3 (POST=4): arm, then 6 samples with pc=0x0,0x4,... -> DONE after the 5th sample.
  - Readout: pc 0x0..0x10, seq 0..4, rd_is_trig=1 only on the first record, rd_count 5..1.
  - The 6th sample is ignored.
- Mode 1, trig_value=0x28, DEPTH=8, PRETRIGGER=3: samples pc 0x0 step 4 -> trigger at seq 10, DONE at seq 14.
  - Readout: 8 records, seq 7..14 (pc 0x1C..0x38), rd_is_trig on the 4th record.
- Mode 2, trig_value=0x63: stream of addi instructions, then a beq at seq 5 -> trigger record has im_instr[6:0]=0x63 and seq 5.
  - Mode 3: 40 samples -> never DONE, busy stays 1.
- Backpressure: in DONE, hold rd_ready=0 for 3 cycles -> rd_* and rd_count stay constant.
  - Then rd_ready=1 continuously -> one record per cycle, and the state is IDLE the cycle after the last record.
- Abort and re-arm: abort during CAPTURE -> IDLE next edge, busy=0, rd_valid=0. arm+abort asserted together -> stays IDLE.
  - A fresh arm with mode 0 afterwards yields records with seq starting at 0.
